// File: rtl/fft_seq_pkg.sv
// rtl/fft_seq_pkg.sv - state encoding, default parameters and timer sizing for the run sequencer
package fft_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    WAIT_LOW,
    WAIT_FFT,
    SETTLE,
    CHECK,
    WAIT_CHK,
    REPORT,
    LOCKED
  } state_t;

  localparam int DEF_START_LEN  = 2;
  localparam int DEF_SETTLE_LEN = 5;
  localparam int DEF_TIMEOUT    = 4096;
  localparam int DEF_CNT_W      = 16;

  function automatic int timer_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/seq_timer.sv
// rtl/seq_timer.sv - loadable down-counter with zero flag, shared by start, settle and watchdog timing
module seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/fft_run_sequencer.sv
// rtl/fft_run_sequencer.sv - sequences one FFT self-test run with watchdog and run/fail counters
// FFT_SEQ_SOAK_EN: a passing run with start_sw still high restarts directly from LOCKED.
module fft_run_sequencer
  import fft_seq_pkg::*;
#(
  parameter int START_LEN  = DEF_START_LEN,
  parameter int SETTLE_LEN = DEF_SETTLE_LEN,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_sw,
  input  logic             unlock,
  input  logic             fft_done,
  input  logic             check_done,
  input  logic             check_q,
  output logic             start_fft,
  output logic             start_comp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [CNT_W-1:0] run_count,
  output logic [CNT_W-1:0] fail_count
);

  localparam int TW = timer_w(TIMEOUT, START_LEN, SETTLE_LEN);

  state_t        state;
  logic          chk_prev;
  logic          chk_rise;
  logic          tmr_load;
  logic          tmr_dec;
  logic [TW-1:0] tmr_val;
  logic          tmr_zero;
  logic          wd_abort;

  assign chk_rise = check_done & ~chk_prev;

  // The timer is (re)loaded on the edge that enters a timed state, so it
  // always starts fresh; otherwise it counts down while in that state.
  always_comb begin
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = TW'(START_LEN - 1);
    wd_abort = 1'b0;
    case (state)
      IDLE, LOCKED: tmr_load = 1'b1;
      START: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(TIMEOUT - 1);
        end else begin
          tmr_dec = 1'b1;
        end
      end
      WAIT_LOW: begin
        if (!fft_done) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(TIMEOUT - 1);
        end else begin
          tmr_dec  = 1'b1;
          wd_abort = tmr_zero;
        end
      end
      WAIT_FFT: begin
        if (fft_done) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(SETTLE_LEN - 1);
        end else begin
          tmr_dec  = 1'b1;
          wd_abort = tmr_zero;
        end
      end
      SETTLE: tmr_dec = 1'b1;
      CHECK: begin
        tmr_load = 1'b1;
        tmr_val  = TW'(TIMEOUT - 1);
      end
      WAIT_CHK: begin
        tmr_dec  = 1'b1;
        wd_abort = tmr_zero & ~chk_rise;
      end
      default: ;
    endcase
  end

  seq_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      chk_prev   <= 1'b0;
      start_fft  <= 1'b0;
      start_comp <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b1;
      pass       <= 1'b0;
      fail       <= 1'b0;
      timeout    <= 1'b0;
      run_count  <= '0;
      fail_count <= '0;
    end else begin
      chk_prev <= check_done;
      case (state)
        IDLE: begin
          if (start_sw) begin
            state     <= START;
            start_fft <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            timeout   <= 1'b0;
          end
        end
        START: begin
          if (tmr_zero) begin
            state     <= WAIT_LOW;
            start_fft <= 1'b0;
          end
        end
        WAIT_LOW: if (!fft_done) state <= WAIT_FFT;
        WAIT_FFT: if (fft_done) state <= SETTLE;
        SETTLE: begin
          if (tmr_zero) begin
            state      <= CHECK;
            start_comp <= 1'b1;
          end
        end
        CHECK: begin
          state      <= WAIT_CHK;
          start_comp <= 1'b0;
        end
        WAIT_CHK: begin
          if (chk_rise) begin
            state <= REPORT;
            pass  <= check_q;
            fail  <= ~check_q;
          end
        end
        REPORT: begin
          state <= LOCKED;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (run_count != '1) run_count <= run_count + 1'b1;
          if (fail && (fail_count != '1)) fail_count <= fail_count + 1'b1;
        end
        LOCKED: begin
          if (unlock) begin
            state <= IDLE;
          end
`ifdef FFT_SEQ_SOAK_EN
          else if (pass && start_sw) begin
            state     <= START;
            start_fft <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            timeout   <= 1'b0;
          end
`endif
        end
        default: state <= IDLE;
      endcase
      // Watchdog expiry overrides whatever the WAIT_* state decided.
      if (wd_abort) begin
        state   <= REPORT;
        timeout <= 1'b1;
        fail    <= 1'b1;
        pass    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_run_sequencer.sv
// tb/tb_fft_run_sequencer.sv - scoreboard bench for fft_run_sequencer (default build, soak disabled)
module tb_fft_run_sequencer;

  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_sw, unlock, fft_done, check_done, check_q;
  logic          start_fft, start_comp, busy, done, pass, fail, timeout;
  logic [CW-1:0] run_count, fail_count;

  typedef struct {
    int p, f, t, rc, fc, nfft, ncomp, lat, nbusy;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  fft_run_sequencer #(
    .START_LEN  (2),
    .SETTLE_LEN (5),
    .TIMEOUT    (64),
    .CNT_W      (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_sw   (start_sw),
    .unlock     (unlock),
    .fft_done   (fft_done),
    .check_done (check_done),
    .check_q    (check_q),
    .start_fft  (start_fft),
    .start_comp (start_comp),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail       (fail),
    .timeout    (timeout),
    .run_count  (run_count),
    .fail_count (fail_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int p, input int f, input int t, input int rc, input int fc,
                      input int ncomp, input int lat, input int nbusy);
    exp_t e;
    e.p = p; e.f = f; e.t = t; e.rc = rc; e.fc = fc;
    e.nfft = 2; e.ncomp = ncomp; e.lat = lat; e.nbusy = nbusy;
    exp_q.push_back(e);
  endtask

  // Monitor: accumulates per-run observations and scores them when done rises.
  initial begin
    int   cyc = 0, rise_cyc = 0;
    int   nfft = 0, ncomp = 0, lat = 0, nbusy = 0;
    bit   skip = 1'b1, prev_done = 1'b1, prev_fft = 1'b1;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        nfft = 0; ncomp = 0; lat = 0; nbusy = 0;
        skip = 1'b1;
      end else begin
        cyc++;
        if (fft_done && !prev_fft) rise_cyc = cyc;
        if (start_fft) nfft++;
        if (start_comp) begin
          ncomp++;
          lat = cyc - rise_cyc;
        end
        if (busy) nbusy++;
        if (done && !prev_done && !skip) begin
          if (exp_q.size() == 0) begin
            expire("unexpected_completion");
          end else begin
            e = exp_q.pop_front();
            chk("pass", int'(pass), e.p);
            chk("fail", int'(fail), e.f);
            chk("timeout", int'(timeout), e.t);
            chk("run_count", int'(run_count), e.rc);
            chk("fail_count", int'(fail_count), e.fc);
            chk("start_fft_cycles", nfft, e.nfft);
            chk("start_comp_pulses", ncomp, e.ncomp);
            chk("fft_done_to_start_comp", lat, e.lat);
            if (e.nbusy >= 0) chk("busy_cycles", nbusy, e.nbusy);
          end
          nfft = 0; ncomp = 0; lat = 0; nbusy = 0;
        end
        skip = 1'b0;
      end
      prev_done = done;
      prev_fft  = fft_done;
    end
  end

  task automatic fft_phase(input bit hang);
    int i;
    for (i = 0; i < 20; i++) begin
      if (start_fft) break;
      tick(1);
    end
    if (i == 20) expire("wait_start_fft");
    fft_done = 1'b0;
    if (!hang) begin
      tick(40);
      fft_done = 1'b1;
    end
  endtask

  task automatic chk_phase(input bit q);
    int i;
    for (i = 0; i < 100; i++) begin
      if (start_comp) break;
      tick(1);
    end
    if (i == 100) expire("wait_start_comp");
    tick(2);
    check_done = 1'b0;
    tick(3);
    check_q    = q;
    check_done = 1'b1;
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 200; i++) begin
      if (done) break;
      tick(1);
    end
    if (i == 200) expire("wait_done");
  endtask

  task automatic do_run(input bit q, input bit hang, input bit hold);
    start_sw = 1'b1;
    tick(1);
    if (!hold) start_sw = 1'b0;
    fft_phase(hang);
    if (!hang) chk_phase(q);
    wait_done();
    if (hang) fft_done = 1'b1;
  endtask

  task automatic unlock_pulse();
    unlock = 1'b1;
    tick(1);
    unlock = 1'b0;
    tick(1);
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, "_flags"}, int'({start_fft, start_comp, busy, done, pass, fail, timeout}), 'b0001000);
    chk({name, "_run_count"}, int'(run_count), 0);
    chk({name, "_fail_count"}, int'(fail_count), 0);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; start_sw = 1'b0; unlock = 1'b0;
    fft_done = 1'b1; check_done = 1'b1; check_q = 1'b0;
    tick(3);
    chk_reset_state("reset");
    rst = 1'b0;
    tick(2);

    // normal pass
    push(1, 0, 0, 1, 0, 1, 6, -1);
    do_run(1'b1, 1'b0, 1'b0);
    unlock_pulse();

    // mismatch, must hold LOCKED until unlock
    push(0, 1, 0, 2, 1, 1, 6, -1);
    do_run(1'b0, 1'b0, 1'b0);
    tick(10);
    chk("mismatch_locked", int'({busy, done}), 'b01);
    unlock_pulse();

    // FFT hang: START 2 + WAIT_LOW 1 + WAIT_FFT 64 + REPORT 1 busy cycles
    push(0, 1, 1, 3, 2, 0, 0, 68);
    do_run(1'b1, 1'b1, 1'b0);
    unlock_pulse();

    // start_sw held through LOCKED: no restart without unlock
    push(1, 0, 0, 4, 2, 1, 6, -1);
    do_run(1'b1, 1'b0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (start_fft) seen = 1'b1;
      tick(1);
    end
    chk("lock_no_restart", int'(seen), 0);
    push(1, 0, 0, 5, 2, 1, 6, -1);
    unlock = 1'b1;
    tick(1);
    unlock = 1'b0;
    chk("unlock_idle_cycle", int'(start_fft), 0);
    tick(1);
    chk("unlock_restart", int'(start_fft), 1);
    start_sw = 1'b0;
    fft_phase(1'b0);
    chk_phase(1'b1);
    wait_done();
    unlock_pulse();

    // run_count saturates at 7 with CNT_W=3
    push(1, 0, 0, 6, 2, 1, 6, -1);
    do_run(1'b1, 1'b0, 1'b0);
    unlock_pulse();
    push(0, 1, 0, 7, 3, 1, 6, -1);
    do_run(1'b0, 1'b0, 1'b0);
    unlock_pulse();
    push(0, 1, 0, 7, 4, 1, 6, -1);
    do_run(1'b0, 1'b0, 1'b0);
    unlock_pulse();

    // reset in SETTLE
    start_sw = 1'b1;
    tick(1);
    start_sw = 1'b0;
    fft_phase(1'b0);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk_reset_state("mid_settle_reset");
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (start_comp || busy) seen = 1'b1;
      tick(1);
    end
    chk("no_start_comp_after_reset", int'(seen), 0);

    // clean run after reset
    push(1, 0, 0, 1, 0, 1, 6, -1);
    do_run(1'b1, 1'b0, 1'b0);
    unlock_pulse();
    tick(5);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
